// File: rtl/sr_seq_if.sv
// Handshake and data bundle for the sequential right shifter.
// The requester drives operands and start; the shifter returns status and result.
interface sr_seq_if #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       mode;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (output start, mode, shamt, in, input busy, done, out);
  modport slave  (input start, mode, shamt, in, output busy, done, out);
endinterface

// File: rtl/sr_seq.sv
// Multi-cycle right shifter: logical, arithmetic or rotate, one bit per clock,
// with a start/busy/done handshake and a registered result.
module sr_seq #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  sr_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       md_q, md_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             fill;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      md_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      md_q    <= md_d;
      out_q   <= out_d;
    end
  end

  // Mode 11 falls into the default arm and behaves as a logical shift.
  always_comb begin
    case (md_q)
      2'b01:   fill = acc_q[WIDTH-1];
      2'b10:   fill = acc_q[0];
      default: fill = 1'b0;
    endcase
    shifted = {fill, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    md_d    = md_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = bus.in;
          cnt_d = bus.shamt;
          md_d  = bus.mode;
          if (bus.shamt == '0) begin
            state_d = DONE;
            out_d   = bus.in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - SW'(1);
        // Last step: publish the shifted value in the same edge that enters DONE.
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
          out_d   = shifted;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
    bus.out  = out_q;
  end

endmodule

// File: tb/tb_sr_seq.sv
// Directed and randomized checks of sr_seq against an arithmetic reference model.
module tb_sr_seq;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sr_seq_if #(.WIDTH(16), .SW(4)) bus ();

  sr_seq #(.WIDTH(16), .SW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [1:0] m,
                                            input int unsigned n);
    logic signed [15:0] s;
    s = a;
    case (m)
      2'b01:   return s >>> n;
      2'b10:   return (n == 0) ? a : ((a >> n) | (a << (16 - n)));
      default: return a >> n;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [1:0] m, input logic [3:0] n,
                       input logic [15:0] exp, input string tag);
    int cyc;
    int lat;
    bus.start = 1'b1;
    bus.in    = a;
    bus.mode  = m;
    bus.shamt = n;
    tick();
    bus.start = 1'b0;
    bus.in    = 16'($urandom);
    bus.mode  = 2'($urandom);
    bus.shamt = 4'($urandom);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      cyc++;
    end
    lat = (n == 0) ? 1 : int'(n) + 1;
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    chk({tag, "_out"}, 32'(bus.out), 32'(exp));
    tick();
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [15:0] v;
    logic [1:0]  m;
    logic [3:0]  n;

    bus.start = 1'b0;
    bus.in    = '0;
    bus.mode  = '0;
    bus.shamt = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;

    do_op(16'hF00F, 2'b00, 4'd4,  16'h0F00, "lsr4");
    do_op(16'h8000, 2'b01, 4'd15, 16'hFFFF, "asr15");
    do_op(16'h8001, 2'b10, 4'd1,  16'hC000, "ror1");
    do_op(16'h1234, 2'b10, 4'd4,  16'h4123, "ror4");
    do_op(16'h1234, 2'b00, 4'd0,  16'h1234, "zero");
    do_op(16'h8000, 2'b11, 4'd1,  16'h4000, "mode11");

    // start pulses during SHIFT and DONE must be dropped
    ndone = 0;
    bus.start = 1'b1; bus.in = 16'h00F0; bus.mode = 2'b00; bus.shamt = 4'd3;
    tick();
    bus.start = 1'b0;
    ndone += int'(bus.done);
    tick();
    ndone += int'(bus.done);
    bus.start = 1'b1; bus.in = 16'hFFFF; bus.shamt = 4'd1;
    tick();
    ndone += int'(bus.done);
    bus.start = 1'b0;
    tick();
    ndone += int'(bus.done);
    chk("sb_done", 32'(bus.done), 32'd1);
    chk("sb_out", 32'(bus.out), 32'h001E);
    bus.start = 1'b1; bus.in = 16'hFFFF; bus.shamt = 4'd0;
    tick();
    bus.start = 1'b0;
    chk("sb_idle_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      ndone += int'(bus.done);
      chk("sb_no_second", 32'(bus.busy), 32'd0);
    end
    chk("sb_pulses", 32'(ndone), 32'd1);
    chk("sb_out_hold", 32'(bus.out), 32'h001E);

    // reset in the middle of a long shift
    do_op(16'hF00F, 2'b00, 4'd4, 16'h0F00, "pre_rst");
    bus.start = 1'b1; bus.in = 16'hABCD; bus.mode = 2'b01; bus.shamt = 4'd10;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_quiet", 32'({bus.busy, bus.done}), 32'd0);
    end
    do_op(16'h0004, 2'b00, 4'd2, 16'h0001, "post_rst");

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_out", 32'(bus.out), 32'h0001);
    end

    // start held high: one accept every shamt+2 cycles
    bus.start = 1'b1;
    bus.shamt = 4'd2;
    for (int k = 0; k < 6; k++) begin
      v = 16'($urandom);
      m = 2'($urandom);
      bus.in   = v;
      bus.mode = m;
      tick();
      chk("b2b_c1", 32'({bus.busy, bus.done}), 32'b10);
      tick();
      chk("b2b_c2", 32'({bus.busy, bus.done}), 32'b10);
      tick();
      chk("b2b_c3", 32'({bus.busy, bus.done}), 32'b11);
      chk("b2b_out", 32'(bus.out), 32'(ref_shift(v, m, 2)));
      tick();
      chk("b2b_idle", 32'({bus.busy, bus.done}), 32'b00);
    end
    bus.start = 1'b0;
    tick();

    for (int k = 0; k < 30; k++) begin
      v = 16'($urandom);
      m = 2'($urandom);
      n = 4'($urandom);
      do_op(v, m, n, ref_shift(v, m, int'(n)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
